// File: rtl/pic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pic_pkg
// Brief    : Shared sprite-box geometry, bitmap size helper and load FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package pic_pkg;

  localparam int BOX_W_DEF = 50;
  localparam int BOX_H_DEF = 50;

  // 1 bpp, rows packed back to back with no per-row padding
  function automatic int nbytes(input int w, input int h);
    return (w * h + 7) / 8;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_t;

endpackage
`default_nettype wire

// File: rtl/pic_bitmap_ram.sv
`default_nettype none
// ============================================================================
// Module   : pic_bitmap_ram
// Brief    : Synchronous 1R1W byte RAM, read-first, block-RAM friendly.
// Revision : 1.0 - initial release
// ============================================================================
module pic_bitmap_ram
  import pic_pkg::*;
#(
  parameter int DEPTH  = nbytes(BOX_W_DEF, BOX_H_DEF),
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] r_mem [DEPTH];

  // Contents are deliberately not reset so this maps onto block RAM
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    rdata <= r_mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/pic_bitmap_store.sv
`default_nettype none
// ============================================================================
// Module   : pic_bitmap_store
// Brief    : 1 bpp sprite bitmap store with 1-cycle pixel fetch and a byte
//            stream loader. Define PIC_BITMAP_DBUF_EN for double buffering.
// Revision : 1.0 - initial release
// ============================================================================
module pic_bitmap_store
  import pic_pkg::*;
#(
  parameter int BOX_W = BOX_W_DEF,
  parameter int BOX_H = BOX_H_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] px,
  input  logic [15:0] py,
  output logic        data,
  input  logic        frame_start,
  input  logic        ld_start,
  input  logic [7:0]  ld_byte,
  input  logic        ld_valid,
  output logic        ld_ready,
  output logic        ld_done
);

  localparam int NBYTES = nbytes(BOX_W, BOX_H);
  localparam int CNT_W  = $clog2(NBYTES);
`ifdef PIC_BITMAP_DBUF_EN
  localparam int DEPTH  = 2 * NBYTES;
`else
  localparam int DEPTH  = NBYTES;
`endif
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NBYTES - 1);

  // ---------------- pixel fetch ----------------
  logic [15:0]       w_bit_addr;
  logic              w_in_range;
  logic [CNT_W-1:0]  w_rd_byte;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [7:0]        w_rd_data;
  logic [2:0]        r_bit_sel;
  logic              r_rd_en;

  assign w_bit_addr = py * 16'(BOX_W) + px;
  assign w_in_range = (px < 16'(BOX_W)) && (py < 16'(BOX_H));
  // Out-of-range coordinates are parked on byte 0 and masked at the output
  assign w_rd_byte  = w_in_range ? CNT_W'(w_bit_addr >> 3) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_sel <= '0;
      r_rd_en   <= 1'b0;
    end else begin
      r_bit_sel <= 3'd7 - w_bit_addr[2:0];
      r_rd_en   <= w_in_range;
    end
  end

  assign data = r_rd_en & w_rd_data[r_bit_sel];

  // ---------------- load FSM ----------------
  ld_state_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ld_ready;
  logic             r_ld_done;
  logic             w_we;
  logic             w_last_wr;

  // A restart pulse takes priority over a byte presented in the same cycle
  assign w_we      = (r_state == ST_LOAD) && ld_valid && !ld_start;
  assign w_last_wr = w_we && (r_cnt == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_ld_ready <= 1'b0;
      r_ld_done  <= 1'b0;
    end else begin
      r_ld_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ld_start) begin
            r_state    <= ST_LOAD;
            r_cnt      <= '0;
            r_ld_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (ld_start) begin
            r_cnt <= '0;
          end else if (ld_valid) begin
            if (r_cnt == C_LAST) begin
              r_state    <= ST_DONE;
              r_ld_ready <= 1'b0;
              r_ld_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_ld_ready <= 1'b0;
        end
      endcase
    end
  end

  assign ld_ready = r_ld_ready;
  assign ld_done  = r_ld_done;

`ifdef PIC_BITMAP_DBUF_EN
  // ---------------- bank swap ----------------
  logic r_bank_sel;
  logic r_swap_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank_sel     <= 1'b0;
      r_swap_pending <= 1'b0;
    end else if (w_last_wr) begin
      r_swap_pending <= 1'b1;
    end else if (ld_start && r_swap_pending) begin
      r_swap_pending <= 1'b0;
    end else if (frame_start && r_swap_pending && (r_state != ST_DONE)) begin
      r_bank_sel     <= ~r_bank_sel;
      r_swap_pending <= 1'b0;
    end
  end

  // Bank 0 occupies [0, NBYTES), bank 1 occupies [NBYTES, 2*NBYTES)
  assign w_rd_addr = r_bank_sel ? ADDR_W'(w_rd_byte) + ADDR_W'(NBYTES) : ADDR_W'(w_rd_byte);
  assign w_wr_addr = r_bank_sel ? ADDR_W'(r_cnt) : ADDR_W'(r_cnt) + ADDR_W'(NBYTES);
`else
  logic w_unused_frame_start;

  assign w_unused_frame_start = frame_start;
  assign w_rd_addr = ADDR_W'(w_rd_byte);
  assign w_wr_addr = ADDR_W'(r_cnt);
`endif

  pic_bitmap_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (w_we),
    .waddr (w_wr_addr),
    .wdata (ld_byte),
    .raddr (w_rd_addr),
    .rdata (w_rd_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_pic_bitmap_store.sv
`default_nettype none
// ============================================================================
// Module   : tb_pic_bitmap_store
// Brief    : Directed self-checking bench for pic_bitmap_store; exercises the
//            double-buffer scenarios when PIC_BITMAP_DBUF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pic_bitmap_store;

  localparam int NB = 313;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] px = '0;
  logic [15:0] py = '0;
  logic        data;
  logic        frame_start = 1'b0;
  logic        ld_start = 1'b0;
  logic [7:0]  ld_byte = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic        ld_done;

  int checks = 0;
  int failures = 0;
  logic [7:0] model [NB];

  always #5 clk = ~clk;

  pic_bitmap_store dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .px          (px),
    .py          (py),
    .data        (data),
    .frame_start (frame_start),
    .ld_start    (ld_start),
    .ld_byte     (ld_byte),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_done     (ld_done)
  );

  function automatic logic exp_bit(input int x, input int y);
    int a;
    if (x >= 50 || y >= 50) return 1'b0;
    a = y * 50 + x;
    return model[a / 8][7 - (a % 8)];
  endfunction

  // All stimulus tasks are entered and left on a negedge.
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    ld_byte  = b;
    ld_valid = 1'b1;
    while (ld_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      failures++;
      $display("FAIL send_byte_timeout: ld_ready=%b after %0d cycles, required 1", ld_ready, t);
    end
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic start_load();
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
  endtask

  task automatic load_model(output int done_seen);
    done_seen = 0;
    start_load();
    for (int i = 0; i < NB; i++) begin
      send_byte(model[i]);
      if (ld_done === 1'b1) done_seen++;
    end
    @(negedge clk);
  endtask

  task automatic read_px(input int x, input int y, output logic d);
    px = 16'(x);
    py = 16'(y);
    @(negedge clk);
    d = data;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    ld_valid = 1'b1;
    ld_byte  = 8'h5A;
    repeat (3) @(negedge clk);
    checks++; if (data !== 1'b0) begin failures++; $display("FAIL reset_data: got %b want 0", data); end
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL reset_ld_ready: got %b want 0", ld_ready); end
    checks++; if (ld_done !== 1'b0) begin failures++; $display("FAIL reset_ld_done: got %b want 0", ld_done); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL idle_ignores_valid: ld_ready got %b want 0", ld_ready); end
    ld_valid = 1'b0;
  endtask

  task automatic test_load_aa();
    int nrdy;
    int ndone;
    logic d;
    nrdy  = 0;
    ndone = 0;
    start_load();
    ld_byte  = 8'hAA;
    ld_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (ld_ready === 1'b1) nrdy++;
      if (ld_done === 1'b1) ndone++;
      @(negedge clk);
    end
    ld_valid = 1'b0;
    for (int i = 0; i < NB; i++) model[i] = 8'hAA;
    checks++; if (nrdy != 313) begin failures++; $display("FAIL aa_ready_cycles: got %0d want 313", nrdy); end
    checks++; if (ndone != 1) begin failures++; $display("FAIL aa_done_pulses: got %0d want 1", ndone); end
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL aa_ready_after: got %b want 0", ld_ready); end
    read_px(0, 0, d);
    checks++; if (d !== 1'b1) begin failures++; $display("FAIL aa_px_0_0: got %b want 1", d); end
    read_px(1, 0, d);
    checks++; if (d !== 1'b0) begin failures++; $display("FAIL aa_px_1_0: got %b want 0", d); end
    read_px(49, 49, d);
    checks++; if (d !== 1'b0) begin failures++; $display("FAIL aa_px_49_49: got %b want 0", d); end
    read_px(48, 49, d);
    checks++; if (d !== 1'b1) begin failures++; $display("FAIL aa_px_48_49: got %b want 1", d); end
  endtask

  task automatic test_latency();
    logic d;
    read_px(1, 0, d);
    px = 16'd0;
    py = 16'd0;
    #1;
    checks++; if (data !== 1'b0) begin failures++; $display("FAIL latency_early: got %b want 0", data); end
    @(negedge clk);
    checks++; if (data !== 1'b1) begin failures++; $display("FAIL latency_one_cycle: got %b want 1", data); end
  endtask

  task automatic test_out_of_range();
    int dn;
    logic d;
    for (int i = 0; i < NB; i++) model[i] = 8'hFF;
    load_model(dn);
    checks++; if (dn != 1) begin failures++; $display("FAIL oor_load_done: got %0d want 1", dn); end
    read_px(50, 0, d);
    checks++; if (d !== 1'b0) begin failures++; $display("FAIL oor_px50: got %b want 0", d); end
    read_px(0, 50, d);
    checks++; if (d !== 1'b0) begin failures++; $display("FAIL oor_py50: got %b want 0", d); end
    read_px(49, 49, d);
    checks++; if (d !== 1'b1) begin failures++; $display("FAIL oor_inrange_49_49: got %b want 1", d); end
    read_px(65535, 0, d);
    checks++; if (d !== 1'b0) begin failures++; $display("FAIL oor_px_max: got %b want 0", d); end
  endtask

  task automatic test_row_packing();
    int dn;
    logic d;
    for (int i = 0; i < NB; i++) model[i] = 8'h00;
    model[6] = 8'h80;
    load_model(dn);
    read_px(48, 0, d);
    checks++; if (d !== 1'b1) begin failures++; $display("FAIL pack_48_0: got %b want 1", d); end
    read_px(47, 0, d);
    checks++; if (d !== 1'b0) begin failures++; $display("FAIL pack_47_0: got %b want 0", d); end
    read_px(49, 0, d);
    checks++; if (d !== 1'b0) begin failures++; $display("FAIL pack_49_0: got %b want 0", d); end
    read_px(0, 1, d);
    checks++; if (d !== 1'b0) begin failures++; $display("FAIL pack_0_1: got %b want 0", d); end
  endtask

  task automatic test_restart();
    int early;
    logic d;
    early = 0;
    start_load();
    for (int i = 0; i < 100; i++) begin
      send_byte(8'h55);
      if (ld_done === 1'b1) early++;
    end
    // restart coinciding with a presented byte: the byte must be dropped
    ld_start = 1'b1;
    ld_valid = 1'b1;
    ld_byte  = 8'hFF;
    @(negedge clk);
    ld_start = 1'b0;
    ld_valid = 1'b0;
    for (int i = 0; i < NB - 1; i++) begin
      send_byte(8'h00);
      if (ld_done === 1'b1) early++;
    end
    send_byte(8'h00);
    checks++; if (ld_done !== 1'b1) begin failures++; $display("FAIL restart_done_at_313: got %b want 1", ld_done); end
    @(negedge clk);
    for (int i = 0; i < NB; i++) model[i] = 8'h00;
    checks++; if (early != 0) begin failures++; $display("FAIL restart_early_done: got %0d want 0", early); end
    read_px(1, 0, d);
    checks++; if (d !== 1'b0) begin failures++; $display("FAIL restart_overwrite_1_0: got %b want 0", d); end
    read_px(48, 0, d);
    checks++; if (d !== 1'b0) begin failures++; $display("FAIL restart_overwrite_48_0: got %b want 0", d); end
  endtask

  task automatic sweep_compare(input string name);
    int bad;
    int bx;
    int by;
    logic d;
    bad = 0;
    bx  = -1;
    by  = -1;
    for (int y = 0; y < 50; y++) begin
      for (int x = 0; x < 50; x++) begin
        read_px(x, y, d);
        if (d !== exp_bit(x, y)) begin
          if (bad == 0) begin bx = x; by = y; end
          bad++;
        end
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s: %0d pixel mismatches, first at (%0d,%0d) got %b want %b",
               name, bad, bx, by, ~exp_bit(bx, by), exp_bit(bx, by));
    end
  endtask

  task automatic test_gaps();
    int rdy;
    rdy = 0;
    ld_valid = 1'b1;
    ld_byte  = 8'hC3;
    repeat (4) begin
      @(negedge clk);
      if (ld_ready === 1'b1) rdy++;
    end
    ld_valid = 1'b0;
    checks++; if (rdy != 0) begin failures++; $display("FAIL gaps_idle_ready: got %0d want 0", rdy); end
    start_load();
    for (int i = 0; i < NB; i++) begin
      model[i] = 8'($urandom);
      ld_byte  = 8'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_byte(model[i]);
    end
    checks++; if (ld_done !== 1'b1) begin failures++; $display("FAIL gaps_done: got %b want 1", ld_done); end
    ld_valid = 1'b1;
    ld_byte  = 8'h3C;
    repeat (5) @(negedge clk);
    ld_valid = 1'b0;
    sweep_compare("gaps_contents");
  endtask

  task automatic test_reset_midload();
    start_load();
    for (int i = 0; i < 10; i++) begin
      send_byte(8'h0F);
      model[i] = 8'h0F;
    end
    rst_n = 1'b0;
    #1;
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL midrst_ready_async: got %b want 0", ld_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    ld_valid = 1'b1;
    ld_byte  = 8'hEE;
    repeat (2) @(negedge clk);
    ld_valid = 1'b0;
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL midrst_idle: got %b want 0", ld_ready); end
    sweep_compare("midrst_partial");
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic test_dbuf();
    int dn;
    logic d;
    for (int i = 0; i < NB; i++) model[i] = 8'hFF;
    load_model(dn);
    pulse_frame();
    read_px(0, 0, d);
    checks++; if (d !== 1'b1) begin failures++; $display("FAIL dbuf_first_swap: got %b want 1", d); end
    start_load();
    for (int i = 0; i < NB; i++) begin
      send_byte(8'h00);
      if (i == 150) begin
        read_px(0, 0, d);
        checks++; if (d !== 1'b1) begin failures++; $display("FAIL dbuf_during_load: got %b want 1", d); end
      end
    end
    checks++; if (ld_done !== 1'b1) begin failures++; $display("FAIL dbuf_done: got %b want 1", ld_done); end
    pulse_frame();
    read_px(0, 0, d);
    checks++; if (d !== 1'b1) begin failures++; $display("FAIL dbuf_frame_in_done_swapped: got %b want 1", d); end
    pulse_frame();
    read_px(0, 0, d);
    checks++; if (d !== 1'b0) begin failures++; $display("FAIL dbuf_swap_to_b: got %b want 0", d); end
    for (int i = 0; i < NB; i++) model[i] = 8'hFF;
    load_model(dn);
    start_load();
    pulse_frame();
    read_px(0, 0, d);
    checks++; if (d !== 1'b0) begin failures++; $display("FAIL dbuf_cancel: got %b want 0", d); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
`ifdef PIC_BITMAP_DBUF_EN
    test_dbuf();
`else
    test_load_aa();
    test_latency();
    test_out_of_range();
    test_row_packing();
    test_restart();
    test_gaps();
    test_reset_midload();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pic_bitmap_store.md
Name: pic_bitmap_store

Overview:
- 1 bpp sprite bitmap memory that answers the pixel-fetch side of the bouncing-box renderer.
- The renderer drives box-relative coordinates (px, py) and consumes the returned pixel bit (data).
- This block stores the bitmap, returns the addressed bit with fixed latency, and accepts bitmap loads over a byte-wide valid/ready stream (UART or ROM loader).

Parameters:
- BOX_W, 50, bitmap width in pixels; must match the renderer's box width.
- BOX_H, 50, bitmap height in pixels.
- NBYTES, (BOX_W*BOX_H+7)/8 = 313, bytes per bitmap; derived, not overridden.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  reset.
- px  in  16  box-relative x.
- py  in  16  box-relative y.
- data  out  1  pixel bit for (px,py); 1 = lit.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- ld_start  in  1  one-cycle pulse; begin (or restart) a bitmap load.
- ld_byte  in  8  load data byte.
- ld_valid  in  1  ld_byte valid.
- ld_ready  out  1  block accepts ld_byte this cycle.
- ld_done  out  1  one-cycle pulse when the last byte has been written.

Behaviour:
- Reset: rst_n is asynchronous and active-low; clk is the clock.
  - Reset values: data=0, ld_ready=0, ld_done=0, state IDLE, byte counter 0, bank select 0, swap_pending 0.
  - RAM contents are not reset.
- Addressing:
  - bit_addr = py*BOX_W + px, computed at 16 bits with no overflow for the default size.
  - Byte address = bit_addr>>3.
  - Bit select = 7-(bit_addr[2:0]); packing is MSB-first, row-major, rows not byte-padded.
- Read latency: exactly 1 clk. data at cycle n+1 reflects px/py at cycle n.
  - If px>=BOX_W or py>=BOX_H at cycle n, data=0 at n+1, regardless of RAM contents.
- Load FSM, states IDLE, LOAD, DONE:
  - IDLE: ld_ready=0; bytes presented are ignored. ld_start -> LOAD, counter<=0.
  - LOAD: ld_ready=1. On ld_valid&&ld_ready, write ld_byte to RAM[counter] and increment the counter.
    - The write at counter==NBYTES-1 -> DONE.
    - ld_start in LOAD resets the counter to 0 and stays in LOAD. If ld_start coincides with an accepted byte, the byte is discarded and ld_start wins.
  - DONE: ld_done=1 for this single cycle, ld_ready=0, -> IDLE unconditionally.
    - ld_start arriving in DONE is honoured on the next cycle only if still asserted; it is a pulse, so it is lost. Loaders must wait for ld_done.
- Write/read collision on the same byte in the same cycle: the read returns old data (read-first).
- Reset mid-load: abort; the partial bitmap stays in RAM and the FSM returns to IDLE.

Optional Feature:
- Macro PIC_BITMAP_DBUF_EN.
- Defined:
  - Two banks. Reads use the front bank (bank_sel); loads write the back bank (~bank_sel).
  - Entering DONE sets swap_pending. On the first frame_start after the DONE cycle with swap_pending=1, bank_sel toggles and swap_pending clears.
  - A frame_start in the DONE cycle itself does not swap.
  - ld_start while swap_pending=1 clears swap_pending, because the back bank is being overwritten.
- Undefined:
  - Single bank; loads write the displayed bitmap directly and tearing is acceptable.
  - frame_start is ignored; swap_pending and bank_sel do not exist.

Decomposition:
- Shared package pic_pkg:
  - BOX_W/BOX_H defaults, shared with the renderer.
  - NBYTES constant function.
  - Load FSM state typedef (IDLE/LOAD/DONE, 2-bit).
- Sub-module pic_bitmap_ram:
  - Synchronous 1R1W byte RAM, depth NBYTES (2*NBYTES with DBUF), read-first.
  - Maps to block RAM.

Test Plan:
- Reset then load 313 bytes of 0xAA with ld_valid held high:
  - ld_ready=1 for exactly 313 accepted cycles, ld_done pulses once, then ld_ready=0.
  - Reading (0,0)=1, (1,0)=0, (49,49) returns bit 2499 (=0, odd index), each 1 cycle after px/py are driven.
- Out-of-range: px=50,py=0 and px=0,py=50 -> data=0 even with an all-0xFF bitmap.
- Row packing: write only byte 6 = 0x80 (other bytes 0) -> only (48,0) reads 1; (0,1) (bit 50, byte 6 bit 5) reads 0.
- Restart: ld_start after 100 bytes, then 313 bytes of 0x00 -> ld_done only after the second full 313; first-load data is fully overwritten.
- Backpressure and gaps: random ld_valid gaps, ld_byte held when not accepted -> contents match a byte-exact model; no writes while IDLE.
- With PIC_BITMAP_DBUF_EN:
  - Load pattern B over displayed pattern A -> reads stay A until the first frame_start after ld_done, then B.
  - A frame_start in the ld_done cycle does not swap.
  - ld_start before the swap cancels it.
